// File: rtl/l1d_lc_request_queue.sv
// l1d_lc_request_queue: in-order L1D-to-lower-cache request FIFO with
// write-to-read forwarding and a single response slot toward L1D.
module l1d_lc_request_queue #(
    parameter int PADDR_BITS = 22,
    parameter int B          = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [511:0]          l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [511:0]          l1_value_out,
    output logic                  l1_wr_done_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [511:0]          lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [511:0]          lc_value_in
);
    localparam int PW  = $clog2(DEPTH);
    localparam int LSB = $clog2(B);

    logic                  we_q   [DEPTH];
    logic [PADDR_BITS-1:0] addr_q [DEPTH];
    logic [511:0]          val_q  [DEPTH];

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic                  fwd_pending_q, fwd_pending_d;
    logic [PADDR_BITS-1:0] fwd_addr_q, fwd_addr_d;
    logic [511:0]          fwd_value_q, fwd_value_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [PADDR_BITS-1:0] resp_addr_q, resp_addr_d;
    logic [511:0]          resp_value_q, resp_value_d;
    logic                  wr_done_q, wr_done_d;
    logic                  run_q, run_d;

    logic          full, empty, l1_acc, push, pop, fwd_set, fwd_load;
    logic          slot_free, lc_acc, hit;
    logic [511:0]  hit_val;
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the youngest matching write wins.
    always_comb begin
        hit     = 1'b0;
        hit_val = '0;
        idx     = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((PW+1)'(k) < count_q && we_q[idx] &&
                addr_q[idx][PADDR_BITS-1:LSB] == l1_addr_in[PADDR_BITS-1:LSB]) begin
                hit     = 1'b1;
                hit_val = val_q[idx];
            end
        end
    end

    always_comb begin
        full          = count_q == (PW+1)'(DEPTH);
        empty         = count_q == '0;
        l1_ready_out  = run_q && !full && !fwd_pending_q;
        l1_acc        = l1_valid_in && l1_ready_out;
        push          = l1_acc && (l1_we_in || !hit);
        fwd_set       = l1_acc && !l1_we_in && hit;
        pop           = !empty && lc_ready_in;
        slot_free     = !resp_valid_q || l1_ready_in;
        lc_ready_out  = run_q && slot_free;
        lc_acc        = lc_valid_in && lc_ready_out;
        fwd_load      = fwd_pending_q && slot_free && !lc_acc;
        head_d        = pop ? head_q + PW'(1) : head_q;
        tail_d        = push ? tail_q + PW'(1) : tail_q;
        count_d       = count_q + (PW+1)'(push) - (PW+1)'(pop);
        fwd_pending_d = fwd_set || (fwd_pending_q && !fwd_load);
        fwd_addr_d    = fwd_set ? l1_addr_in : fwd_addr_q;
        fwd_value_d   = fwd_set ? hit_val : fwd_value_q;
        resp_valid_d  = lc_acc || fwd_load || (resp_valid_q && !l1_ready_in);
        resp_addr_d   = lc_acc ? lc_addr_in : fwd_load ? fwd_addr_q : resp_addr_q;
        resp_value_d  = lc_acc ? lc_value_in : fwd_load ? fwd_value_q : resp_value_q;
        wr_done_d     = pop && we_q[head_q];
        run_d         = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fwd_pending_q <= 1'b0;
            fwd_addr_q    <= '0;
            fwd_value_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_addr_q   <= '0;
            resp_value_q  <= '0;
            wr_done_q     <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fwd_pending_q <= fwd_pending_d;
            fwd_addr_q    <= fwd_addr_d;
            fwd_value_q   <= fwd_value_d;
            resp_valid_q  <= resp_valid_d;
            resp_addr_q   <= resp_addr_d;
            resp_value_q  <= resp_value_d;
            wr_done_q     <= wr_done_d;
            run_q         <= run_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk_in) begin
        if (push) begin
            we_q[tail_q]   <= l1_we_in;
            addr_q[tail_q] <= l1_addr_in;
            val_q[tail_q]  <= l1_we_in ? l1_value_in : '0;
        end
    end

    always_comb begin
        lc_valid_out   = !empty;
        lc_addr_out    = empty ? '0 : addr_q[head_q];
        lc_value_out   = empty ? '0 : val_q[head_q];
        lc_we_out      = !empty && we_q[head_q];
        l1_valid_out   = resp_valid_q;
        l1_addr_out    = resp_addr_q;
        l1_value_out   = resp_value_q;
        l1_wr_done_out = wr_done_q;
    end
endmodule

// File: tb/tb_l1d_lc_request_queue.sv
// tb_l1d_lc_request_queue: directed scoreboard bench; expected lc requests and
// L1 responses are queued when stimulus is driven and checked on handshakes.
module tb_l1d_lc_request_queue;
    logic          clk_in = 1'b0;
    logic          rst_N_in;
    logic          l1_valid_in, l1_ready_out, l1_we_in;
    logic [21:0]   l1_addr_in;
    logic [511:0]  l1_value_in;
    logic          l1_valid_out, l1_ready_in;
    logic [21:0]   l1_addr_out;
    logic [511:0]  l1_value_out;
    logic          l1_wr_done_out;
    logic          lc_valid_out, lc_ready_in, lc_we_out;
    logic [21:0]   lc_addr_out;
    logic [511:0]  lc_value_out;
    logic          lc_valid_in, lc_ready_out;
    logic [21:0]   lc_addr_in;
    logic [511:0]  lc_value_in;

    typedef struct { logic we; logic [21:0] a; logic [511:0] v; } lc_t;
    typedef struct { logic [21:0] a; logic [511:0] v; } rs_t;
    lc_t exp_lc[$];
    rs_t exp_rs[$];
    lc_t ml;
    rs_t mr;
    int total = 0, bad = 0, wr_cnt = 0, snap = 0;

    always #5 clk_in = ~clk_in;

    l1d_lc_request_queue dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out), .l1_addr_in(l1_addr_in),
        .l1_value_in(l1_value_in), .l1_we_in(l1_we_in),
        .l1_valid_out(l1_valid_out), .l1_ready_in(l1_ready_in), .l1_addr_out(l1_addr_out),
        .l1_value_out(l1_value_out), .l1_wr_done_out(l1_wr_done_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
        .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
        .lc_value_in(lc_value_in)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_N_in) begin
            if (l1_wr_done_out) wr_cnt++;
            if (l1_valid_out && l1_ready_in) begin
                chk("resp_expected", 512'(exp_rs.size() != 0), 512'd1);
                if (exp_rs.size() != 0) begin
                    mr = exp_rs.pop_front();
                    chk("resp_addr", 512'(l1_addr_out), 512'(mr.a));
                    chk("resp_value", l1_value_out, mr.v);
                end
            end
            if (lc_valid_out && lc_ready_in) begin
                chk("lc_expected", 512'(exp_lc.size() != 0), 512'd1);
                if (exp_lc.size() != 0) begin
                    ml = exp_lc.pop_front();
                    chk("lc_we", 512'(lc_we_out), 512'(ml.we));
                    chk("lc_addr", 512'(lc_addr_out), 512'(ml.a));
                    chk("lc_value", lc_value_out, ml.v);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic l1_req(input logic we, input logic [21:0] a, input logic [511:0] v,
                          input logic fwd, input logic [511:0] fv);
        logic ok = 1'b0;
        if (we || !fwd) exp_lc.push_back('{we, a, we ? v : 512'd0});
        if (fwd) exp_rs.push_back('{a, fv});
        l1_valid_in = 1'b1; l1_we_in = we; l1_addr_in = a; l1_value_in = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            ok = l1_ready_out;
        end
        chk("l1_accept", 512'(ok), 512'd1);
        @(posedge clk_in);
        #1;
        l1_valid_in = 1'b0;
    endtask

    task automatic lc_resp(input logic [21:0] a, input logic [511:0] v);
        logic ok = 1'b0;
        exp_rs.push_back('{a, v});
        lc_valid_in = 1'b1; lc_addr_in = a; lc_value_in = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_in);
            ok = lc_ready_out;
        end
        chk("lc_accept", 512'(ok), 512'd1);
        @(posedge clk_in);
        #1;
        lc_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_lc.size() != 0; i++) cyc(1);
        chk("drain", 512'(exp_lc.size()), 512'd0);
        cyc(2);
    endtask

    initial begin
        rst_N_in = 1'b0; l1_valid_in = 1'b0; l1_we_in = 1'b0; l1_addr_in = '0;
        l1_value_in = '0; l1_ready_in = 1'b1; lc_ready_in = 1'b0; lc_valid_in = 1'b0;
        lc_addr_in = '0; lc_value_in = '0;
        #2;
        chk("rst_l1_ready", 512'(l1_ready_out), 512'd0);
        chk("rst_lc_ready", 512'(lc_ready_out), 512'd0);
        chk("rst_l1_valid", 512'(l1_valid_out), 512'd0);
        chk("rst_lc_valid", 512'(lc_valid_out), 512'd0);
        chk("rst_lc_addr", 512'(lc_addr_out), 512'd0);
        chk("rst_l1_value", l1_value_out, 512'd0);
        cyc(2);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("post_rst_l1_ready", 512'(l1_ready_out), 512'd1);
        chk("post_rst_lc_ready", 512'(lc_ready_out), 512'd1);

        // Read miss pass-through; l1_value_in on a read must be ignored.
        lc_ready_in = 1'b1;
        l1_req(1'b0, 22'h001000, 512'hBAD, 1'b0, '0);
        chk("miss_lc_valid", 512'(lc_valid_out), 512'd1);
        chk("miss_lc_we", 512'(lc_we_out), 512'd0);
        chk("miss_lc_addr", 512'(lc_addr_out), 512'h001000);
        cyc(1);
        lc_resp(22'h001000, 512'hDEADBEEF);
        chk("miss_l1_valid", 512'(l1_valid_out), 512'd1);
        chk("miss_l1_value", l1_value_out, 512'hDEADBEEF);
        cyc(2);

        // Write then forwarding read.
        lc_ready_in = 1'b0;
        snap = wr_cnt;
        l1_req(1'b1, 22'h004000, 512'hC0C0C0C0, 1'b0, '0);
        l1_req(1'b0, 22'h004010, 512'hBAD, 1'b1, 512'hC0C0C0C0);
        chk("fwd_blocks_ready", 512'(l1_ready_out), 512'd0);
        chk("fwd_min_latency", 512'(l1_valid_out), 512'd0);
        cyc(1);
        chk("fwd_l1_valid", 512'(l1_valid_out), 512'd1);
        chk("fwd_l1_value", l1_value_out, 512'hC0C0C0C0);
        chk("fwd_ready_back", 512'(l1_ready_out), 512'd1);
        lc_ready_in = 1'b1;
        drain();
        chk("fwd_wr_done", 512'(wr_cnt - snap), 512'd1);

        // Fill to full, drain in order, then wrap the pointers.
        lc_ready_in = 1'b0;
        snap = wr_cnt;
        for (int i = 1; i <= 4; i++)
            l1_req(1'b1, 22'(i << 12), 512'(i * 32'h11), 1'b0, '0);
        chk("full_ready", 512'(l1_ready_out), 512'd0);
        chk("full_head", 512'(lc_addr_out), 512'h001000);
        lc_ready_in = 1'b1;
        drain();
        chk("full_wr_done", 512'(wr_cnt - snap), 512'd4);
        lc_ready_in = 1'b0;
        l1_req(1'b1, 22'h005000, 512'h55, 1'b0, '0);
        l1_req(1'b1, 22'h006000, 512'h66, 1'b0, '0);
        chk("wrap_head", 512'(lc_addr_out), 512'h005000);
        lc_ready_in = 1'b1;
        drain();

        // Forward collides with an lc response: lc wins, forward next.
        lc_ready_in = 1'b0;
        l1_req(1'b1, 22'h008000, 512'hA5A5, 1'b0, '0);
        lc_valid_in = 1'b1; lc_addr_in = 22'h009000; lc_value_in = 512'h5555;
        exp_rs.push_back('{22'h009000, 512'h5555});
        l1_req(1'b0, 22'h008000, 512'h0, 1'b1, 512'hA5A5);
        chk("col_lc_first", 512'(l1_addr_out), 512'h009000);
        chk("col_ready_low", 512'(l1_ready_out), 512'd0);
        lc_valid_in = 1'b0;
        cyc(1);
        chk("col_fwd_second", 512'(l1_addr_out), 512'h008000);
        chk("col_fwd_value", l1_value_out, 512'hA5A5);
        chk("col_ready_back", 512'(l1_ready_out), 512'd1);
        lc_ready_in = 1'b1;
        drain();

        // Backpressure with a reload on the releasing cycle.
        l1_ready_in = 1'b0;
        lc_resp(22'h00A000, 512'h77);
        lc_valid_in = 1'b1; lc_addr_in = 22'h00B000; lc_value_in = 512'h88;
        exp_rs.push_back('{22'h00B000, 512'h88});
        for (int i = 0; i < 3; i++) begin
            chk("bp_lc_ready", 512'(lc_ready_out), 512'd0);
            chk("bp_addr_stable", 512'(l1_addr_out), 512'h00A000);
            chk("bp_value_stable", l1_value_out, 512'h77);
            cyc(1);
        end
        l1_ready_in = 1'b1;
        cyc(1);
        lc_valid_in = 1'b0;
        chk("bp_reload_valid", 512'(l1_valid_out), 512'd1);
        chk("bp_reload_addr", 512'(l1_addr_out), 512'h00B000);
        cyc(1);
        chk("bp_cleared", 512'(l1_valid_out), 512'd0);

        // Reset mid-operation with three writes queued and a held response.
        lc_ready_in = 1'b0;
        l1_ready_in = 1'b0;
        for (int i = 1; i <= 3; i++)
            l1_req(1'b1, 22'(i << 12), 512'(i), 1'b0, '0);
        lc_resp(22'h00C000, 512'hCC);
        rst_N_in = 1'b0;
        #1;
        chk("mid_rst_lc_valid", 512'(lc_valid_out), 512'd0);
        chk("mid_rst_l1_valid", 512'(l1_valid_out), 512'd0);
        chk("mid_rst_l1_ready", 512'(l1_ready_out), 512'd0);
        exp_lc.delete();
        exp_rs.delete();
        snap = wr_cnt;
        @(negedge clk_in);
        rst_N_in = 1'b1;
        lc_ready_in = 1'b1;
        l1_ready_in = 1'b1;
        cyc(1);
        chk("rel_l1_ready", 512'(l1_ready_out), 512'd1);
        chk("rel_lc_valid", 512'(lc_valid_out), 512'd0);
        chk("rel_l1_valid", 512'(l1_valid_out), 512'd0);
        cyc(4);
        chk("rel_no_wr_done", 512'(wr_cnt - snap), 512'd0);
        chk("end_resp_q", 512'(exp_rs.size()), 512'd0);
        chk("end_lc_q", 512'(exp_lc.size()), 512'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
